four_bit_alu_sequencer: RTL and testbench

Control FSM that sequences one ALU operation through the four-bit datapath. It accepts a start request with two operands and an opcode, then drives the A and B register latch strobes and their data buses in turn. It holds the ALU opcode for a programmable number of execute cycles, captures the ALU result into an output register, and signals completion. It sits between the instruction/test front end and the `four_bit_register` / ALU datapath of Part 2.

---
 rtl/four_bit_alu_sequencer_pkg.sv | 24 ++
 rtl/four_bit_alu_sequencer_exec_cycle_counter.sv | 44 ++++
 rtl/four_bit_alu_sequencer.sv | 146 ++++++++++++++
 tb/tb_four_bit_alu_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/four_bit_alu_sequencer_pkg.sv
// four_bit_alu_sequencer_pkg
//   Shared definitions for the ALU sequencer: FSM state encoding, ALU opcode
//   values and the width of the execute-cycle counter.
package four_bit_alu_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_A = 3'd1,
      S_LOAD_B = 3'd2,
      S_EXEC   = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } opcode_e;

   localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/four_bit_alu_sequencer_exec_cycle_counter.sv
// exec_cycle_counter
//   Loadable down-counter that times the EXEC phase of the ALU sequencer.
//   Ports:
//     clk      - clock, rising edge
//     rst_n    - asynchronous active-low reset, clears the count
//     load     - load load_val on the next edge (has priority over en)
//     load_val - value to load
//     en       - decrement on the next edge
//     zero     - count currently reads 0
module exec_cycle_counter
   import four_bit_alu_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Saturates at zero so a stray enable cannot wrap the count.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/four_bit_alu_sequencer.sv
// four_bit_alu_sequencer
//   Control FSM that runs one ALU operation through the datapath: capture the
//   request, strobe the A then B register, hold the opcode for EXEC_CYCLES,
//   capture the ALU result and pulse done.
//   Ports:
//     clk, rst_n            - clock / asynchronous active-low reset
//     start                 - request, sampled only in IDLE
//     opcode                - 00 ADD, 01 SUB, 10 AND, 11 OR
//     operand_a, operand_b  - operands, captured with start
//     alu_result, alu_carry - ALU output from the datapath
//     A, B                  - captured operands to the A/B registers
//     latch_a, latch_b      - A/B register load strobes
//     alu_op                - opcode to the ALU (00 outside LOAD_A..WRITE)
//     busy                  - high in every state except IDLE
//     done                  - one-cycle completion pulse
//     result, carry         - registered ALU result and carry
module four_bit_alu_sequencer
   import four_bit_alu_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned EXEC_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       opcode,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             latch_a,
   output logic             latch_b,
   output logic [1:0]       alu_op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(EXEC_CYCLES - 1);

   state_e           state_q, state_d;
   opcode_e          op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             cnt_load;
   logic             cnt_en;
   logic             cnt_zero;

   exec_cycle_counter u_exec_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (EXEC_LOAD),
      .en       (cnt_en),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= OP_ADD;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         carry_q  <= carry_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      carry_d  = carry_q;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      latch_a  = 1'b0;
      latch_b  = 1'b0;
      done     = 1'b0;
      busy     = 1'b1;
      alu_op   = op_q;

      unique case (state_q)
         S_IDLE: begin
            busy   = 1'b0;
            alu_op = OP_ADD;
            if (start) begin
               state_d = S_LOAD_A;
               op_d    = opcode_e'(opcode);
               a_d     = operand_a;
               b_d     = operand_b;
            end
         end
         S_LOAD_A: begin
            latch_a = 1'b1;
            state_d = S_LOAD_B;
         end
         S_LOAD_B: begin
            latch_b  = 1'b1;
            cnt_load = 1'b1;
            state_d  = S_EXEC;
         end
         S_EXEC: begin
            // Counter reads EXEC_CYCLES-1 on the first EXEC cycle, so leaving
            // on zero gives exactly EXEC_CYCLES cycles here.
            if (cnt_zero) begin
               state_d = S_WRITE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         S_WRITE: begin
            result_d = alu_result;
            carry_d  = alu_carry;
            state_d  = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            alu_op  = OP_ADD;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign A      = a_q;
   assign B      = b_q;
   assign result = result_q;
   assign carry  = carry_q;

endmodule

// File: tb/tb_four_bit_alu_sequencer.sv
// tb_four_bit_alu_sequencer
//   Two sequencers (EXEC_CYCLES 1 and 3) share one stimulus stream. Each has
//   a stand-in ALU datapath and a cycle-count model of the operation timeline
//   checked every cycle, plus hand-computed literal checks.
module tb_four_bit_alu_sequencer;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [1:0] opcode = 2'b00;
   logic [3:0] opa = 4'h0;
   logic [3:0] opb = 4'h0;

   logic [3:0] alu_r  [2];
   logic       alu_c  [2];
   logic [3:0] A_o    [2];
   logic [3:0] B_o    [2];
   logic [3:0] res_o  [2];
   logic [1:0] aop_o  [2];
   logic       la_o   [2];
   logic       lb_o   [2];
   logic       busy_o [2];
   logic       done_o [2];
   logic       car_o  [2];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   four_bit_alu_sequencer #(.WIDTH(4), .EXEC_CYCLES(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
      .operand_a(opa), .operand_b(opb),
      .alu_result(alu_r[0]), .alu_carry(alu_c[0]),
      .A(A_o[0]), .B(B_o[0]), .latch_a(la_o[0]), .latch_b(lb_o[0]),
      .alu_op(aop_o[0]), .busy(busy_o[0]), .done(done_o[0]),
      .result(res_o[0]), .carry(car_o[0])
   );

   four_bit_alu_sequencer #(.WIDTH(4), .EXEC_CYCLES(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
      .operand_a(opa), .operand_b(opb),
      .alu_result(alu_r[1]), .alu_carry(alu_c[1]),
      .A(A_o[1]), .B(B_o[1]), .latch_a(la_o[1]), .latch_b(lb_o[1]),
      .alu_op(aop_o[1]), .busy(busy_o[1]), .done(done_o[1]),
      .result(res_o[1]), .carry(car_o[1])
   );

   // ALU function: {carry/borrow, result}
   function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
      case (op)
         2'b00:   return {1'b0, a} + {1'b0, b};
         2'b01:   return {(a < b), 4'(a - b)};
         2'b10:   return {1'b0, a & b};
         default: return {1'b0, a | b};
      endcase
   endfunction

   assign {alu_c[0], alu_r[0]} = alu_f(A_o[0], B_o[0], aop_o[0]);
   assign {alu_c[1], alu_r[1]} = alu_f(A_o[1], B_o[1], aop_o[1]);

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: an operation is a run of cycles numbered 1..4+N after the start
   // edge; result is computed from the captured operands at the end of 3+N.
   int unsigned ncyc [2] = '{1, 3};
   bit          m_act [2];
   int unsigned m_cyc [2];
   bit [3:0]    m_a   [2];
   bit [3:0]    m_b   [2];
   bit [1:0]    m_op  [2];
   bit [3:0]    m_res [2];
   bit          m_car [2];

   always @(posedge clk or negedge rst_n) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            m_act[d] = 1'b0; m_cyc[d] = 0; m_a[d] = '0; m_b[d] = '0;
            m_op[d] = '0; m_res[d] = '0; m_car[d] = 1'b0;
         end else if (!m_act[d]) begin
            if (start) begin
               m_act[d] = 1'b1; m_cyc[d] = 1;
               m_a[d] = opa; m_b[d] = opb; m_op[d] = opcode;
            end
         end else if (m_cyc[d] == 4 + ncyc[d]) begin
            m_act[d] = 1'b0; m_cyc[d] = 0;
         end else begin
            if (m_cyc[d] == 3 + ncyc[d]) {m_car[d], m_res[d]} = alu_f(m_a[d], m_b[d], m_op[d]);
            m_cyc[d]++;
         end
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("dut%0d busy", d),    8'(busy_o[d]), 8'(m_act[d]));
         chk($sformatf("dut%0d latch_a", d), 8'(la_o[d]),   8'(m_act[d] && m_cyc[d] == 1));
         chk($sformatf("dut%0d latch_b", d), 8'(lb_o[d]),   8'(m_act[d] && m_cyc[d] == 2));
         chk($sformatf("dut%0d done", d),    8'(done_o[d]), 8'(m_act[d] && m_cyc[d] == 4 + ncyc[d]));
         chk($sformatf("dut%0d alu_op", d),  8'(aop_o[d]),
             8'((m_act[d] && m_cyc[d] <= 3 + ncyc[d]) ? m_op[d] : 2'b00));
         chk($sformatf("dut%0d A", d),       8'(A_o[d]),    8'(m_a[d]));
         chk($sformatf("dut%0d B", d),       8'(B_o[d]),    8'(m_b[d]));
         chk($sformatf("dut%0d result", d),  8'(res_o[d]),  8'(m_res[d]));
         chk($sformatf("dut%0d carry", d),   8'(car_o[d]),  8'(m_car[d]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns #1 into cycle 1 of the new operation.
   task automatic launch(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      opcode = op; opa = a; opb = b; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int ndone0, ndone1, nbusy_low, dsum;
      bit dn [12];
      bit bz [12];

      #1 rst_n = 1'b0;
      tick();
      chk("reset busy",   8'(busy_o[0]), 8'h0);
      chk("reset result", 8'(res_o[0]),  8'h0);
      chk("reset A",      8'(A_o[0]),    8'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // ADD 0101 + 0011
      launch(2'b00, 4'b0101, 4'b0011);
      chk("add c1 latch_a", 8'(la_o[0]), 8'h1);
      chk("add c1 A",       8'(A_o[0]),  8'h5);
      tick();
      chk("add c2 latch_b", 8'(lb_o[0]), 8'h1);
      chk("add c2 B",       8'(B_o[0]),  8'h3);
      tick(); tick();
      chk("add c4 done",    8'(done_o[0]), 8'h0);
      tick();
      chk("add c5 done",    8'(done_o[0]), 8'h1);
      chk("add c5 result",  8'(res_o[0]),  8'h8);
      chk("add c5 carry",   8'(car_o[0]),  8'h0);
      repeat (6) tick();

      // SUB 0111 - 1101 on EXEC_CYCLES=3
      launch(2'b01, 4'b0111, 4'b1101);
      tick(); tick();
      for (int c = 3; c <= 5; c++) begin
         chk($sformatf("sub c%0d exec op", c),   8'(aop_o[1]),  8'h1);
         chk($sformatf("sub c%0d exec done", c), 8'(done_o[1]), 8'h0);
         chk($sformatf("sub c%0d exec lb", c),   8'(lb_o[1]),   8'h0);
         tick();
      end
      chk("sub c6 done",      8'(done_o[1]), 8'h0);
      chk("sub c6 old result", 8'(res_o[1]), 8'h8);
      tick();
      chk("sub c7 done",   8'(done_o[1]), 8'h1);
      chk("sub c7 result", 8'(res_o[1]),  8'hA);
      chk("sub c7 carry",  8'(car_o[1]),  8'h1);
      repeat (4) tick();

      // Inputs changed and start pulsed while busy
      launch(2'b00, 4'b0101, 4'b0011);
      tick();
      opa = 4'b1111; start = 1'b1;
      tick();
      start = 1'b0;
      chk("ignore c3 A", 8'(A_o[0]), 8'h5);
      ndone0 = 0; ndone1 = 0;
      for (int c = 4; c <= 12; c++) begin
         tick();
         if (done_o[0]) ndone0++;
         if (done_o[1]) ndone1++;
      end
      chk("ignore done count dut0", 8'(ndone0), 8'h1);
      chk("ignore done count dut1", 8'(ndone1), 8'h1);
      chk("ignore idle after",      8'(busy_o[0]), 8'h0);
      opa = 4'b0000;

      // Reset during EXEC
      launch(2'b00, 4'b0101, 4'b0011);
      tick(); tick();
      chk("rst pre busy", 8'(busy_o[0]), 8'h1);
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst dut%0d busy", d),   8'(busy_o[d]), 8'h0);
         chk($sformatf("rst dut%0d A", d),      8'(A_o[d]),    8'h0);
         chk($sformatf("rst dut%0d B", d),      8'(B_o[d]),    8'h0);
         chk($sformatf("rst dut%0d alu_op", d), 8'(aop_o[d]),  8'h0);
         chk($sformatf("rst dut%0d result", d), 8'(res_o[d]),  8'h0);
         chk($sformatf("rst dut%0d done", d),   8'(done_o[d]), 8'h0);
      end
      tick();
      rst_n = 1'b1;
      ndone0 = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (done_o[0] || done_o[1]) ndone0++;
      end
      chk("rst no done", 8'(ndone0), 8'h0);
      launch(2'b00, 4'b1110, 4'b0001);
      repeat (4) tick();
      chk("post rst done",   8'(done_o[0]), 8'h1);
      chk("post rst result", 8'(res_o[0]),  8'hF);
      repeat (6) tick();

      // start held for two operations: AND 1100 & 1010
      opcode = 2'b10; opa = 4'b1100; opb = 4'b1010; start = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         tick();
         dn[c] = done_o[0];
         bz[c] = busy_o[0];
      end
      start = 1'b0;
      dsum = 0; nbusy_low = 0;
      for (int c = 1; c <= 11; c++) begin
         if (dn[c]) dsum++;
         if (!bz[c]) nbusy_low++;
      end
      chk("cont done c5",    8'(dn[5]),      8'h1);
      chk("cont done c11",   8'(dn[11]),     8'h1);
      chk("cont done count", 8'(dsum),       8'h2);
      chk("cont busy gap",   8'(nbusy_low),  8'h1);
      chk("cont idle c6",    8'(bz[6]),      8'h0);
      chk("cont result",     8'(res_o[0]),   8'h8);
      repeat (10) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
